// File: rtl/display_source_arbiter.sv
// ---------------------------------------------------------------------------
// display_source_arbiter
//
// Round-robin arbiter that shares the four-digit 7-segment display between
// three BCD producers: the multiplier result (source 0), operand A entry
// (source 1) and operand B entry (source 2).
//
// A requester is served with a one-cycle ack pulse. Its 16-bit BCD word is
// checked at the same time:
//   - A legal word is latched for the display multiplexer. The display is
//     then held for HOLD_CYCLES cycles before anyone else may take it.
//   - A word with any nibble above 9 is acked together with err. It is
//     discarded, and the arbiter stays free for the next cycle.
//
// Ports
//   clk        in   1  system clock, rising edge
//   reset      in   1  asynchronous, active-high reset
//   req        in   3  request per source (0 result, 1 operand A, 2 operand B)
//   data_0..2  in  16  BCD word per source, thousands digit in [15:12]
//   ack        out  3  one-hot, one-cycle accept pulse to the served source
//   err        out  1  pulse alongside ack when the served word is not BCD
//   BCD_code   out 16  latched display word
//   valid_BCD  out  1  set once any legal word has been latched
//   owner      out  2  source index of the word currently shown
//   busy       out  1  high while the display hold is running
// ---------------------------------------------------------------------------
module display_source_arbiter #(
  parameter int HOLD_CYCLES = 27_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  req,
  input  logic [15:0] data_0,
  input  logic [15:0] data_1,
  input  logic [15:0] data_2,
  output logic [2:0]  ack,
  output logic        err,
  output logic [15:0] BCD_code,
  output logic        valid_BCD,
  output logic [1:0]  owner,
  output logic        busy
);

  localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
  // The counter is loaded with HOLD_CYCLES-1 on a grant. The HOLD state then
  // lasts HOLD_CYCLES cycles, including the final cycle spent at zero.
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       last_q, last_d;
  logic [2:0]       ack_q, ack_d;
  logic             err_q, err_d;
  logic [15:0]      bcd_q, bcd_d;
  logic             valid_q, valid_d;
  logic [1:0]       owner_q, owner_d;
  logic             busy_q, busy_d;

  // -------------------------------------------------------------------------
  // Per-source BCD legality: every nibble must be 0..9.
  // -------------------------------------------------------------------------
  logic [15:0] src_data [3];
  logic [2:0]  src_legal;

  assign src_data[0] = data_0;
  assign src_data[1] = data_1;
  assign src_data[2] = data_2;

  genvar gi, gj;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_legal
      logic [3:0] nib_ok;
      for (gj = 0; gj < 4; gj++) begin : g_nib
        assign nib_ok[gj] = (src_data[gi][4*gj +: 4] <= 4'd9);
      end
      assign src_legal[gi] = &nib_ok;
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Round-robin pick.
  // The search starts at (last+1) mod 3. The loop runs from the farthest
  // candidate back to the nearest, so the nearest requester writes last and
  // wins.
  // -------------------------------------------------------------------------
  function automatic logic [1:0] rr_pick(input logic [2:0] r, input logic [1:0] last);
    logic [1:0] pick;
    logic [2:0] sum;
    logic [1:0] cand;
    pick = 2'd0;
    for (int k = 2; k >= 0; k--) begin
      sum  = {1'b0, last} + 3'd1 + 3'(k);
      cand = (sum >= 3'd3) ? 2'(sum - 3'd3) : 2'(sum);
      if (r[cand]) begin
        pick = cand;
      end
    end
    return pick;
  endfunction

  logic [1:0]  sel;
  logic [15:0] sel_data;
  logic        sel_legal;

  assign sel = rr_pick(req, last_q);

  always_comb begin
    sel_data  = data_2;
    sel_legal = src_legal[2];
    case (sel)
      2'd0: begin
        sel_data  = data_0;
        sel_legal = src_legal[0];
      end
      2'd1: begin
        sel_data  = data_1;
        sel_legal = src_legal[1];
      end
      default: begin
        sel_data  = data_2;
        sel_legal = src_legal[2];
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Next-state logic.
  // ack and err are single-cycle pulses, so they default to 0.
  // The display registers default to holding their value.
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    ack_d   = 3'b000;
    err_d   = 1'b0;
    bcd_d   = bcd_q;
    valid_d = valid_q;
    owner_d = owner_q;
    busy_d  = busy_q;

    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (|req) begin
          // Rotation advances on every grant, including rejected words,
          // so a source sending bad data cannot monopolise the arbiter.
          last_d = sel;
          ack_d  = 3'b001 << sel;
          if (sel_legal) begin
            bcd_d   = sel_data;
            owner_d = sel;
            valid_d = 1'b1;
            cnt_d   = HOLD_LOAD;
            state_d = HOLD;
            busy_d  = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      HOLD: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          cnt_d  = cnt_q - CNT_W'(1);
          busy_d = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State and output registers.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= 2'd2;   // source 0 has first priority after reset
      ack_q   <= 3'b000;
      err_q   <= 1'b0;
      bcd_q   <= 16'h0000;
      valid_q <= 1'b0;
      owner_q <= 2'd0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      bcd_q   <= bcd_d;
      valid_q <= valid_d;
      owner_q <= owner_d;
      busy_q  <= busy_d;
    end
  end

  assign ack       = ack_q;
  assign err       = err_q;
  assign BCD_code  = bcd_q;
  assign valid_BCD = valid_q;
  assign owner     = owner_q;
  assign busy      = busy_q;

  // -------------------------------------------------------------------------
  // Structural invariants of the handshake.
  // -------------------------------------------------------------------------
  a_ack_onehot0 : assert property (@(posedge clk) disable iff (reset) $onehot0(ack_q));
  a_err_has_ack : assert property (@(posedge clk) disable iff (reset) err_q |-> (ack_q != 3'b000));
  a_busy_valid  : assert property (@(posedge clk) disable iff (reset) busy_q |-> valid_q);

endmodule

// File: tb/tb_display_source_arbiter.sv
// ---------------------------------------------------------------------------
// tb_display_source_arbiter
//
// Self-checking bench for display_source_arbiter, run with HOLD_CYCLES = 4.
//
// A behavioural model tracks the arbiter using plain variables:
//   - the remaining number of busy cycles,
//   - the last served source index,
//   - the displayed word.
// The model and the DUT are compared every clock. Directed scenarios come
// first, followed by a randomized phase. One line is printed per
// transaction.
// ---------------------------------------------------------------------------
module tb_display_source_arbiter;

  localparam int H = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  req;
  logic [15:0] data_0, data_1, data_2;
  logic [2:0]  ack;
  logic        err;
  logic [15:0] BCD_code;
  logic        valid_BCD;
  logic [1:0]  owner;
  logic        busy;

  display_source_arbiter #(.HOLD_CYCLES(H)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .data_0    (data_0),
    .data_1    (data_1),
    .data_2    (data_2),
    .ack       (ack),
    .err       (err),
    .BCD_code  (BCD_code),
    .valid_BCD (valid_BCD),
    .owner     (owner),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // ---------------- reference model ----------------
  int          m_last;
  int          m_busy_left;   // busy cycles still to be shown
  logic [15:0] m_bcd;
  logic        m_valid;
  int          m_owner;
  logic [2:0]  m_ack;
  logic        m_err;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic bit bcd_ok(input logic [15:0] w);
    for (int j = 0; j < 4; j++) begin
      if (((w >> (4 * j)) & 16'hF) > 9) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic logic [15:0] src_word(input int i);
    if (i == 0) return data_0;
    if (i == 1) return data_1;
    return data_2;
  endfunction

  task automatic model_reset();
    m_last      = 2;
    m_busy_left = 0;
    m_bcd       = 16'h0000;
    m_valid     = 1'b0;
    m_owner     = 0;
    m_ack       = 3'b000;
    m_err       = 1'b0;
  endtask

  task automatic model_edge();
    int w;
    m_ack = 3'b000;
    m_err = 1'b0;
    if (reset) begin
      model_reset();
      return;
    end
    if (m_busy_left > 0) begin
      m_busy_left--;
      return;
    end
    w = -1;
    for (int k = 1; k <= 3; k++) begin
      if (w < 0 && req[(m_last + k) % 3]) w = (m_last + k) % 3;
    end
    if (w >= 0) begin
      m_last = w;
      m_ack  = 3'(1 << w);
      if (bcd_ok(src_word(w))) begin
        m_bcd       = src_word(w);
        m_owner     = w;
        m_valid     = 1'b1;
        m_busy_left = H;
      end else begin
        m_err = 1'b1;
      end
    end
  endtask

  task automatic check_all(input string tag);
    check_val({tag, ".ack"},   32'(ack),       32'(m_ack));
    check_val({tag, ".err"},   32'(err),       32'(m_err));
    check_val({tag, ".bcd"},   32'(BCD_code),  32'(m_bcd));
    check_val({tag, ".valid"}, 32'(valid_BCD), 32'(m_valid));
    check_val({tag, ".owner"}, 32'(owner),     32'(m_owner));
    check_val({tag, ".busy"},  32'(busy),      32'(m_busy_left > 0));
  endtask

  // One clock: advance the model at the edge, then compare 1 ns later.
  task automatic tick(input string tag);
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
    check_all(tag);
    if (m_ack != 3'b000)
      $display("[%0d] %s req=%b ack=%b err=%b bcd=%h owner=%0d busy=%b",
               cyc, tag, req, ack, err, BCD_code, owner, busy);
  endtask

  task automatic set_src(input int i, input logic [15:0] w);
    if (i == 0) data_0 = w;
    else if (i == 1) data_1 = w;
    else data_2 = w;
  endtask

  task automatic drop_acked();
    req = req & ~m_ack;
  endtask

  task automatic ticks(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      tick(tag);
      drop_acked();
    end
  endtask

  function automatic logic [15:0] rand_word();
    logic [15:0] w;
    int p;
    for (int j = 0; j < 4; j++) w[4*j +: 4] = 4'($urandom_range(0, 9));
    if ($urandom_range(0, 4) == 0) begin
      p = $urandom_range(0, 3);
      w[4*p +: 4] = 4'($urandom_range(10, 15));
    end
    return w;
  endfunction

  initial begin
    int cnt;
    int g_idx[$];
    int g_cyc[$];
    logic [15:0] g_bcd[$];

    reset = 1'b1;
    req = 3'b000;
    data_0 = 16'h0000;
    data_1 = 16'h0000;
    data_2 = 16'h0000;
    model_reset();

    // ---- reset values ----
    @(posedge clk);
    @(posedge clk);
    #1;
    check_val("rst.ack",   32'(ack), 32'h0);
    check_val("rst.err",   32'(err), 32'h0);
    check_val("rst.bcd",   32'(BCD_code), 32'h0);
    check_val("rst.valid", 32'(valid_BCD), 32'h0);
    check_val("rst.owner", 32'(owner), 32'h0);
    check_val("rst.busy",  32'(busy), 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // ---- single grant of source 0, then measure the busy window ----
    data_0 = 16'h1234;
    req = 3'b001;
    tick("t1");
    check_val("t1.ack",   32'(ack), 32'h1);
    check_val("t1.bcd",   32'(BCD_code), 32'h1234);
    check_val("t1.valid", 32'(valid_BCD), 32'h1);
    check_val("t1.owner", 32'(owner), 32'h0);
    drop_acked();
    cnt = (busy === 1'b1) ? 1 : 0;
    for (int i = 0; i < 20 && busy === 1'b1; i++) begin
      tick("t1.hold");
      if (busy === 1'b1) cnt++;
    end
    check_val("t1.busy_len", 32'(cnt), 32'(H));

    // ---- source 1 requests while the display is held for source 0 ----
    ticks(2, "t3.idle");
    data_0 = 16'h0042;
    req = 3'b001;
    tick("t3.g0");
    drop_acked();
    data_1 = 16'h0567;
    req = 3'b010;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick("t3.wait");
      cnt++;
      if (ack !== 3'b000) break;
    end
    check_val("t3.ack1",   32'(ack), 32'h2);
    check_val("t3.latency", 32'(cnt), 32'(H + 1));
    drop_acked();

    // ---- illegal word on source 2, then source 0 one cycle later ----
    ticks(H + 1, "t4.idle");
    data_2 = 16'h12A4;
    req = 3'b100;
    tick("t4.bad");
    check_val("t4.ack",  32'(ack), 32'h4);
    check_val("t4.err",  32'(err), 32'h1);
    check_val("t4.bcd",  32'(BCD_code), 32'h0567);
    check_val("t4.busy", 32'(busy), 32'h0);
    drop_acked();
    data_0 = 16'h0099;
    req = 3'b001;
    tick("t4.next");
    check_val("t4.ack0", 32'(ack), 32'h1);
    check_val("t4.bcd0", 32'(BCD_code), 32'h0099);
    drop_acked();
    ticks(H + 1, "t4.idle2");

    // ---- async reset in mid HOLD; 3'b111 afterwards goes to source 0 ----
    data_0 = 16'h0001;
    data_1 = 16'h0002;
    data_2 = 16'h0003;
    req = 3'b111;
    tick("t5.g");
    tick("t5.h");
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check_all("t5.async");
    check_val("t5.async_busy", 32'(busy), 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // ---- continuous 3'b111: rotation 0,1,2,0 spaced H+1 cycles ----
    for (int i = 0; i < 3 * (H + 1) + 1; i++) begin
      tick("t2");
      if (ack !== 3'b000) begin
        g_idx.push_back((ack == 3'b001) ? 0 : (ack == 3'b010) ? 1 : 2);
        g_cyc.push_back(i);
        g_bcd.push_back(BCD_code);
      end
    end
    check_val("t2.ngrants", 32'(g_idx.size()), 32'd4);
    if (g_idx.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        check_val($sformatf("t2.src%0d", i), 32'(g_idx[i]), 32'(i % 3));
        check_val($sformatf("t2.bcd%0d", i), 32'(g_bcd[i]), 32'((i % 3) + 1));
        if (i > 0)
          check_val($sformatf("t2.gap%0d", i), 32'(g_cyc[i] - g_cyc[i-1]), 32'(H + 1));
      end
    end
    req = 3'b000;
    ticks(H + 1, "t2.drain");

    // ---- randomized phase ----
    for (int n = 0; n < 1500; n++) begin
      tick("rnd");
      // Requesters normally drop req after ack; sometimes one re-requests.
      for (int i = 0; i < 3; i++) begin
        if (m_ack[i] && $urandom_range(0, 7) != 0) req[i] = 1'b0;
      end
      for (int i = 0; i < 3; i++) begin
        if (!req[i] && $urandom_range(0, 3) == 0) begin
          set_src(i, rand_word());
          req[i] = 1'b1;
        end
      end
      if ($urandom_range(0, 299) == 0) begin
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check_all("rnd.async");
        @(negedge clk);
        reset = 1'b0;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
